dnn_infer_ctrl: RTL and testbench

Job-level sequencer for the fixed-point MNIST inference engine. It owns the shared single-port image/weight memory, gives the host write access while idle, and hands the port to the engine for a run. It then starts the engine, waits for completion, and reduces the 10 class scores to an argmax. It sits between the host/testbench loader and the `dnn_relu_fix*` engine wrapper, and presents a valid/ready result channel.

---
 rtl/dnn_infer_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dnn_infer_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_infer_ctrl.sv
// dnn_infer_ctrl: job-level sequencer for the fixed-point MNIST inference engine.
//
// Owns the shared single-port image/weight memory. While idle the host has
// the port; during a run the engine's read address drives it. A job clears
// and starts the engine, waits for completion, snapshots the class scores,
// reduces them to an argmax, and presents the winner on a result channel.
//
// Optional feature macro: DNN_CTRL_WATCHDOG_EN
//   defined   -> WAIT is bounded by TIMEOUT_CYCLES; expiry yields an error result
//   undefined -> WAIT lasts until eng_done or job_abort; res_err tied to 0
//
// Ports:
//   clk, rst (sync, active-low)
//   host_we/host_addr/host_wdata -> host write request; host_wr_ack accepted
//   job_go, job_abort            -> start / cancel a job
//   busy                         -> registered, high outside IDLE
//   mem_addr/mem_we/mem_wdata    -> shared memory port
//   eng_start, eng_reset         -> registered one-cycle engine pulses
//   eng_done, eng_mem_addr, eng_out -> engine status, read address, scores
//   res_valid/res_ready          -> result handshake
//   res_class, res_score, res_err -> result payload
//   dbg_state                    -> current FSM state for observation
//
// Result handshake: res_valid rises with a stable payload (res_class,
// res_score, res_err); the payload holds until an edge samples
// res_valid && res_ready, after which res_valid drops on the next cycle.
module dnn_infer_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 18,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 host_we,
  input  logic [ADDR_WIDTH-1:0]                host_addr,
  input  logic [DATA_WIDTH-1:0]                host_wdata,
  output logic                                 host_wr_ack,
  input  logic                                 job_go,
  input  logic                                 job_abort,
  output logic                                 busy,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic                                 mem_we,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic                                 eng_start,
  output logic                                 eng_reset,
  input  logic                                 eng_done,
  input  logic [ADDR_WIDTH-1:0]                eng_mem_addr,
  input  logic signed [DATA_WIDTH*NUM_CLASSES-1:0] eng_out,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [3:0]                           res_class,
  output logic signed [DATA_WIDTH-1:0]         res_score,
  output logic                                 res_err,
  output logic [2:0]                           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_ARGMAX = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t state, state_n;

  logic signed [DATA_WIDTH-1:0] score_q [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best_q, best_n, cur;
  logic [3:0] k_q, idx_q, idx_n;
  logic       upd, last_k, done_hit, timeout_hit, wd_fire, res_hs;
  logic       eng_reset_n, eng_start_n;

  assign dbg_state = state;
  assign res_hs    = res_valid && res_ready;
  assign done_hit  = (state == S_WAIT) && eng_done && !job_abort;

  // Argmax step: k=0 seeds the running best; later entries win only when
  // strictly greater, so ties keep the lowest index.
  assign cur    = score_q[k_q];
  assign last_k = (k_q == 4'(NUM_CLASSES - 1));
  assign upd    = (k_q == 4'd0) || (cur > best_q);
  assign best_n = upd ? cur : best_q;
  assign idx_n  = upd ? k_q : idx_q;

`ifdef DNN_CTRL_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        res_err_q;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst)                wd_cnt <= '0;
    else if (state != S_WAIT) wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 16'd1;
  end
  assign timeout_hit = (state == S_WAIT) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst)                              res_err_q <= 1'b0;
    else if (wd_fire)                      res_err_q <= 1'b1;
    else if (state == S_ARGMAX && last_k)  res_err_q <= 1'b0;
  end
  assign res_err = res_err_q;
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  assign wd_fire = (state == S_WAIT) && (state_n == S_RESULT);

  // Next state plus the next values of the registered engine pulses.
  always_comb begin
    state_n     = state;
    eng_reset_n = 1'b0;
    eng_start_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_go) begin
          state_n     = S_CLEAR;
          eng_reset_n = 1'b1;
        end
      end
      S_CLEAR: begin
        if (job_abort) begin
          state_n     = S_IDLE;
          eng_reset_n = 1'b1;
        end else begin
          state_n     = S_START;
          eng_start_n = 1'b1;
        end
      end
      S_START: begin
        if (job_abort) begin
          state_n     = S_IDLE;
          eng_reset_n = 1'b1;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Abort beats a coincident done.
        if (job_abort) begin
          state_n     = S_IDLE;
          eng_reset_n = 1'b1;
        end else if (eng_done) begin
          state_n = S_ARGMAX;
        end else if (timeout_hit) begin
          state_n     = S_RESULT;
          eng_reset_n = 1'b1;
        end
      end
      S_ARGMAX: begin
        if (last_k) state_n = S_RESULT;
      end
      S_RESULT: begin
        if (res_hs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      eng_reset <= 1'b0;
      eng_start <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_class <= 4'd0;
      res_score <= '0;
      k_q       <= 4'd0;
      idx_q     <= 4'd0;
      best_q    <= '0;
    end else begin
      state     <= state_n;
      eng_reset <= eng_reset_n;
      eng_start <= eng_start_n;
      busy      <= (state_n != S_IDLE);
      // Rises one cycle after RESULT is entered, with the payload already settled.
      res_valid <= (state == S_RESULT) && !res_hs;

      if (done_hit) begin
        for (int i = 0; i < NUM_CLASSES; i++)
          score_q[i] <= eng_out[i*DATA_WIDTH +: DATA_WIDTH];
        k_q <= 4'd0;
      end

      if (state == S_ARGMAX) begin
        k_q    <= k_q + 4'd1;
        best_q <= best_n;
        idx_q  <= idx_n;
        if (last_k) begin
          res_class <= idx_n;
          res_score <= best_n;
        end
      end

      if (wd_fire) begin
        res_class <= 4'hF;
        res_score <= '0;
      end
    end
  end

  // Host owns the port only in IDLE; otherwise the engine reads and host
  // writes are silently dropped.
  always_comb begin
    if (state == S_IDLE) begin
      mem_addr    = host_addr;
      mem_we      = host_we;
      host_wr_ack = host_we;
    end else begin
      mem_addr    = eng_mem_addr;
      mem_we      = 1'b0;
      host_wr_ack = 1'b0;
    end
  end
  assign mem_wdata = host_wdata;

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Self-checking bench for dnn_infer_ctrl with a randomized engine model and
// a behavioural argmax reference feeding an expected-result queue.
module tb_dnn_infer_ctrl;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int NC = 10;
`ifdef DNN_CTRL_WATCHDOG_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               host_we = 1'b0;
  logic [AW-1:0]      host_addr = '0;
  logic [DW-1:0]      host_wdata = '0;
  logic               host_wr_ack;
  logic               job_go = 1'b0;
  logic               job_abort = 1'b0;
  logic               busy;
  logic [AW-1:0]      mem_addr;
  logic               mem_we;
  logic [DW-1:0]      mem_wdata;
  logic               eng_start;
  logic               eng_reset;
  logic               eng_done = 1'b0;
  logic [AW-1:0]      eng_mem_addr = '0;
  logic [DW*NC-1:0]   eng_out = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [3:0]         res_class;
  logic [DW-1:0]      res_score;
  logic               res_err;
  logic [2:0]         dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0]  exp_q[$];
  logic [DW-1:0] sc [NC];

  dnn_infer_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_wr_ack(host_wr_ack),
    .job_go(job_go), .job_abort(job_abort), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .eng_start(eng_start), .eng_reset(eng_reset), .eng_done(eng_done),
    .eng_mem_addr(eng_mem_addr), .eng_out(eng_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score), .res_err(res_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first index holding the largest signed score; returns {class, score}.
  function automatic logic [19:0] ref_argmax(input logic [DW-1:0] s [NC]);
    int bi = 0;
    for (int i = 1; i < NC; i++)
      if ($signed(s[i]) > $signed(s[bi])) bi = i;
    return {4'(bi), s[bi]};
  endfunction

  task automatic start_job();
    job_go = 1'b1;
    tick();
    job_go = 1'b0;
    check("clr_reset", 32'(eng_reset), 32'd1);
    check("clr_start", 32'(eng_start), 32'd0);
    check("clr_busy",  32'(busy),      32'd1);
    tick();
    check("st_start", 32'(eng_start), 32'd1);
    check("st_reset", 32'(eng_reset), 32'd0);
    tick();
    check("wait_start", 32'(eng_start), 32'd0);
    check("wait_busy",  32'(busy),      32'd1);
  endtask

  // Full job: engine finishes after lat WAIT cycles with scores sc[].
  task automatic run_job(input int lat, input bit arb, input int hold);
    int n;
    logic [19:0] exp;
    start_job();
    for (int i = 0; i < lat; i++) begin
      if (arb && i == lat / 2) begin
        host_we      = 1'b1;
        host_addr    = AW'($urandom);
        eng_mem_addr = AW'($urandom);
        #1;
        check("arb_addr", 32'(mem_addr),    32'(eng_mem_addr));
        check("arb_we",   32'(mem_we),      32'd0);
        check("arb_ack",  32'(host_wr_ack), 32'd0);
        host_we = 1'b0;
      end
      tick();
    end
    for (int c = 0; c < NC; c++) eng_out[c*DW +: DW] = sc[c];
    eng_done = 1'b1;
    exp_q.push_back(ref_argmax(sc));
    tick();
    eng_done = 1'b0;
    eng_out  = {5{$urandom}};
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    check("res_latency", 32'(n), 32'd11);
    exp = exp_q.pop_front();
    check("res_class", 32'(res_class), 32'(exp[19:16]));
    check("res_score", 32'(res_score), 32'(exp[15:0]));
    check("res_err",   32'(res_err),   32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_class", 32'(res_class), 32'(exp[19:16]));
      check("hold_score", 32'(res_score), 32'(exp[15:0]));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_valid", 32'(res_valid), 32'd0);
    check("post_busy",  32'(busy),      32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_reset", 32'(eng_reset), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    rst = 1'b1;
    tick();

    // Nominal: host write, then a job with class 7 winning.
    host_we = 1'b1; host_addr = 18'h5; host_wdata = 16'h1234;
    #1;
    check("wr_addr",  32'(mem_addr),    32'h5);
    check("wr_data",  32'(mem_wdata),   32'h1234);
    check("wr_we",    32'(mem_we),      32'd1);
    check("wr_ack",   32'(host_wr_ack), 32'd1);
    tick();
    host_we = 1'b0;
    for (int c = 0; c < NC; c++) sc[c] = 16'h1000;
    sc[7] = 16'h3000;
    run_job(50, 1'b1, 3);

    // Tie between 2 and 5 over negative background.
    for (int c = 0; c < NC; c++) sc[c] = 16'hF000;
    sc[2] = 16'h2000; sc[5] = 16'h2000;
    run_job(7, 1'b0, 1);

    // All most-negative.
    for (int c = 0; c < NC; c++) sc[c] = 16'h8000;
    run_job(3, 1'b0, 0);

    // Randomized jobs, half drawn from a small value set to force ties.
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < NC; c++) begin
        if (j[0]) begin
          case ($urandom_range(0, 3))
            0: sc[c] = 16'h8000;
            1: sc[c] = 16'h7FFF;
            2: sc[c] = 16'h0000;
            default: sc[c] = 16'hFFFF;
          endcase
        end else begin
          sc[c] = DW'($urandom);
        end
      end
      run_job($urandom_range(0, 30), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Abort coincident with done.
    start_job();
    repeat (4) tick();
    for (int c = 0; c < NC; c++) eng_out[c*DW +: DW] = DW'($urandom);
    eng_done = 1'b1; job_abort = 1'b1;
    tick();
    eng_done = 1'b0; job_abort = 1'b0;
    check("abt_reset", 32'(eng_reset), 32'd1);
    check("abt_busy",  32'(busy),      32'd0);
    host_we = 1'b1; host_addr = 18'h2A;
    #1;
    check("abt_idle_ack", 32'(host_wr_ack), 32'd1);
    host_we = 1'b0;
    tick();
    check("abt_reset_end", 32'(eng_reset), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("abt_no_result", 32'(seen), 32'd0);

`ifdef DNN_CTRL_WATCHDOG_EN
    // Engine never finishes: error result after the watchdog.
    start_job();
    seen = 0;
    while (!res_valid && seen < 300) begin
      tick();
      seen++;
    end
    check("wd_valid", 32'(res_valid), 32'd1);
    check("wd_err",   32'(res_err),   32'd1);
    check("wd_class", 32'(res_class), 32'hF);
    check("wd_score", 32'(res_score), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("wd_post_busy", 32'(busy), 32'd0);
`else
    // Engine never finishes: WAIT persists, then abort to recover.
    start_job();
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("nowd_busy",  32'(busy), 32'd1);
    check("nowd_valid", 32'(seen), 32'd0);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("nowd_abort_busy", 32'(busy), 32'd0);
    tick();
`endif

    // Reset in WAIT.
    start_job();
    repeat (5) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("mrst_busy",  32'(busy),      32'd0);
    check("mrst_start", 32'(eng_start), 32'd0);
    check("mrst_reset", 32'(eng_reset), 32'd0);
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_err",   32'(res_err),   32'd0);
    rst = 1'b1;
    host_we = 1'b1; host_addr = 18'h5;
    #1;
    check("mrst_addr", 32'(mem_addr),    32'h5);
    check("mrst_we",   32'(mem_we),      32'd1);
    check("mrst_ack",  32'(host_wr_ack), 32'd1);
    host_we = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
